// File: rtl/lfsr_rand_range.sv
// rtl/lfsr_rand_range.sv - Galois LFSR random source with bounded draw port
module lfsr_rand_range #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
  parameter int              OUT_W     = 6,
  parameter int              MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] raw
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    REDUCE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] lfsr, lfsr_next, lfsr_step;
  logic [TRY_W-1:0] tries, tries_next;
  logic [OUT_W-1:0] lim, lim_next;
  logic [OUT_W-1:0] rem, rem_next;
  logic [OUT_W-1:0] value_next;
  logic             valid_next;
  logic [OUT_W:0]   limit_eff;
  logic [OUT_W-1:0] cand;

  // One Galois shift; the outgoing LSB decides whether the taps fold back in.
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

  // Seed load wins over stepping; a zero seed is swapped for SEED to avoid lockup.
  always_comb begin
    lfsr_next = lfsr;
    if (seed_load) begin
      lfsr_next = (seed_in == '0) ? SEED : seed_in;
    end else if (en || (state == DRAW)) begin
      lfsr_next = lfsr_step;
    end
  end

  // Latched limit of zero stands for the full 2^OUT_W range.
  always_comb begin
    limit_eff = (lim == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, lim};
    cand      = lfsr[OUT_W-1:0];
  end

  // Draw FSM: rejection sampling on the pre-step state, then a subtract-based modulo.
  always_comb begin
    state_next = state;
    tries_next = tries;
    lim_next   = lim;
    rem_next   = rem;
    value_next = value;
    valid_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          lim_next   = limit;
          tries_next = '0;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if ({1'b0, cand} < limit_eff) begin
          value_next = cand;
          valid_next = 1'b1;
          state_next = IDLE;
        end else if (tries == LAST_TRY) begin
          rem_next   = cand;
          state_next = REDUCE;
        end else begin
          tries_next = tries + 1'b1;
        end
      end
      REDUCE: begin
        // limit_eff is below 2^OUT_W whenever rem can reach it, so the low bits suffice.
        if ({1'b0, rem} >= limit_eff) begin
          rem_next = rem - limit_eff[OUT_W-1:0];
        end else begin
          value_next = rem;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any draw in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED;
      tries <= '0;
      lim   <= '0;
      rem   <= '0;
      value <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_next;
      tries <= tries_next;
      lim   <= lim_next;
      rem   <= rem_next;
      value <= value_next;
      valid <= valid_next;
    end
  end

  assign busy = (state != IDLE);
  assign raw  = lfsr;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// tb/tb_lfsr_rand_range.sv - self-checking bench for lfsr_rand_range
module tb_lfsr_rand_range;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        req = 1'b0;
  logic [5:0]  limit = '0;

  logic        busy_a, valid_a, busy_b, valid_b;
  logic [5:0]  value_a, value_b;
  logic [15:0] raw_a, raw_b;

  int checks = 0;
  int failures = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];

  always #5 clk = ~clk;

  lfsr_rand_range #(.MAX_TRIES(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .limit(limit), .busy(busy_a), .valid(valid_a), .value(value_a), .raw(raw_a)
  );

  lfsr_rand_range #(.MAX_TRIES(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .limit(limit), .busy(busy_b), .valid(valid_b), .value(value_b), .raw(raw_b)
  );

  always @(negedge clk) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_draw(input logic [15:0] s_in, input logic [5:0] lim, input int mt,
                            output logic [5:0] v, output logic [15:0] s_out);
    int le;
    int tries;
    int r;
    logic [15:0] s;
    bit done;
    le = (lim == 0) ? 64 : int'(lim);
    tries = 0;
    s = s_in;
    done = 0;
    v = '0;
    while (!done) begin
      r = int'(s[5:0]);
      s = f_step(s);
      if (r < le) begin
        v = 6'(r);
        done = 1;
      end else if (tries == mt - 1) begin
        while (r >= le) r = r - le;
        v = 6'(r);
        done = 1;
      end else begin
        tries++;
      end
    end
    s_out = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  // Raises req, holds it for 'hold' edges, then watches both instances until each has
  // produced a valid; each valid pops and compares its scoreboard entry.
  task automatic do_draw(input int hold, output int lat_a, output int lat_b);
    logic [5:0] e;
    lat_a = -1;
    lat_b = -1;
    req = 1'b1;
    for (int k = 0; k < 200 && (lat_a < 0 || lat_b < 0); k++) begin
      tick();
      if (k + 1 >= hold) req = 1'b0;
      if (valid_a && lat_a < 0) begin
        lat_a = k;
        chk("sb_a_nonempty", 32'(q_a.size() > 0), 32'd1);
        chk("busy_a_drops_with_valid", 32'(busy_a), 32'd0);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          chk("value_a", 32'(value_a), 32'(e));
        end
      end
      if (valid_b && lat_b < 0) begin
        lat_b = k;
        chk("sb_b_nonempty", 32'(q_b.size() > 0), 32'd1);
        chk("busy_b_drops_with_valid", 32'(busy_b), 32'd0);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          chk("value_b", 32'(value_b), 32'(e));
        end
      end
    end
    req = 1'b0;
    if (lat_a < 0) chk("timeout_a", 32'd0, 32'd1);
    if (lat_b < 0) chk("timeout_b", 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] seq [6];
    logic [15:0] ms_a, ms_b, tmp;
    logic [5:0]  v;
    int la, lb, va0, vb0;

    seq[0] = 16'hACE1; seq[1] = 16'hE270; seq[2] = 16'h7138;
    seq[3] = 16'h389C; seq[4] = 16'h1C4E; seq[5] = 16'h0E27;

    // Reset state and idle hold
    #1;
    tick();
    chk("reset_raw", 32'(raw_a), 32'hACE1);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_value", 32'(value_a), 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_raw_hold", 32'(raw_a), 32'hACE1);
    chk("idle_no_valid", 32'(vcnt_a + vcnt_b), 32'd0);
    chk("idle_busy", 32'(busy_a | busy_b), 32'd0);
    chk("idle_value", 32'(value_a), 32'd0);

    // Free-run sequence
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("freerun_%0d", i), 32'(raw_a), 32'(seq[i]));
      tick();
    end
    en = 1'b0;

    // limit=40 from reset: single DRAW accepting 33
    do_reset();
    limit = 6'd40;
    q_a.push_back(6'd33);
    q_b.push_back(6'd33);
    do_draw(1, la, lb);
    chk("lim40_latency_a", 32'(la), 32'd1);
    chk("lim40_raw_after", 32'(raw_a), 32'hE270);

    // limit=20: A rejects four then accepts 14; B falls back to REDUCE giving 8
    do_reset();
    limit = 6'd20;
    q_a.push_back(6'd14);
    q_b.push_back(6'd8);
    do_draw(1, la, lb);
    chk("lim20_latency_a", 32'(la), 32'd5);
    chk("lim20_latency_b", 32'(lb), 32'd5);
    tick();
    chk("lim20_raw_a", 32'(raw_a), 32'h0E27);
    chk("lim20_raw_b_no_step_in_reduce", 32'(raw_b), 32'h7138);

    // Seed load beats step, zero seed replaced
    do_reset();
    en = 1'b1;
    tick();
    chk("seed_pre_step", 32'(raw_a), 32'hE270);
    seed_load = 1'b1;
    seed_in = 16'h0000;
    tick();
    chk("seed_zero_to_default", 32'(raw_a), 32'hACE1);
    seed_in = 16'h0001;
    tick();
    chk("seed_one", 32'(raw_a), 32'h0001);
    seed_load = 1'b0;
    tick();
    chk("seed_one_step", 32'(raw_a), 32'hB400);
    en = 1'b0;

    // Reset mid-draw aborts with no valid
    do_reset();
    limit = 6'd20;
    va0 = vcnt_a;
    vb0 = vcnt_b;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("middraw_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_a | busy_b), 32'd0);
    chk("abort_valid", 32'(valid_a | valid_b), 32'd0);
    chk("abort_raw", 32'(raw_a), 32'hACE1);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("abort_no_valid", 32'((vcnt_a - va0) + (vcnt_b - vb0)), 32'd0);

    // req held while busy plus limit change mid-draw: one result, limit unaffected
    va0 = vcnt_a;
    vb0 = vcnt_b;
    limit = 6'd20;
    q_a.push_back(6'd14);
    q_b.push_back(6'd8);
    fork
      begin
        tick();
        tick();
        limit = 6'd63;
      end
    join_none
    do_draw(4, la, lb);
    repeat (10) tick();
    chk("held_req_single_valid_a", 32'(vcnt_a - va0), 32'd1);
    chk("held_req_single_valid_b", 32'(vcnt_b - vb0), 32'd1);

    // limit=0 accepts low bits in one DRAW
    do_reset();
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    limit = 6'd0;
    q_a.push_back(6'h1C);
    q_b.push_back(6'h1C);
    do_draw(1, la, lb);
    chk("lim0_latency", 32'(la), 32'd1);
    ms_a = 16'h1C4E;
    ms_b = 16'h1C4E;

    // limit=1 always yields 0, then random limits against the model
    limit = 6'd1;
    q_a.push_back(6'd0);
    q_b.push_back(6'd0);
    model_draw(ms_a, 6'd1, 8, v, tmp); ms_a = tmp;
    model_draw(ms_b, 6'd1, 2, v, tmp); ms_b = tmp;
    do_draw(1, la, lb);
    repeat (2) tick();
    chk("lim1_raw_a", 32'(raw_a), 32'(ms_a));
    chk("lim1_raw_b", 32'(raw_b), 32'(ms_b));
    for (int i = 0; i < 6; i++) begin
      limit = 6'($urandom_range(0, 63));
      model_draw(ms_a, limit, 8, v, tmp); ms_a = tmp; q_a.push_back(v);
      model_draw(ms_b, limit, 2, v, tmp); ms_b = tmp; q_b.push_back(v);
      do_draw(1, la, lb);
      repeat (2) tick();
      chk($sformatf("rand_raw_a_%0d", i), 32'(raw_a), 32'(ms_a));
      chk($sformatf("rand_raw_b_%0d", i), 32'(raw_b), 32'(ms_b));
    end
    chk("sb_drained", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_range.md
Name: lfsr_rand_range

Overview:
Parametrised Galois LFSR pseudo-random source. It replaces the fixed 9-bit generator. Adds runtime seeding, a free-run enable, and a request/valid draw port that returns a value uniformly bounded to [0, limit-1] using rejection sampling, with a bounded-retry modulo fallback. It feeds apple/object placement logic in the snake game, one draw per coordinate.

Parameters:
WIDTH, 16, LFSR state width (>= OUT_W+2)
TAPS, 16'hB400, Galois feedback mask, XORed into the shifted state when the outgoing LSB is 1
SEED, 16'hACE1, reset state; also substituted for any zero seed
OUT_W, 6, width of bounded output and limit
MAX_TRIES, 8, rejection attempts before modulo fallback (>= 1)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
en  in  1  free-run step: LFSR advances one step per cycle while high
seed_load  in  1  load seed_in into LFSR this edge
seed_in  in  WIDTH  seed value; 0 is replaced by SEED
req  in  1  draw request, sampled only in IDLE
limit  in  OUT_W  exclusive upper bound, latched when req is accepted; 0 means 2^OUT_W (full range)
busy  out  1  high while a draw is in progress (DRAW or REDUCE)
valid  out  1  one-cycle pulse: value holds a new result
value  out  OUT_W  bounded result, held until the next valid
raw  out  WIDTH  current LFSR state

Behaviour:
- Reset (async, rst=1): state=SEED, FSM=IDLE, busy=0, valid=0, value=0, try counter=0, latched limit=0. Reset mid-draw aborts the draw with no valid.
- LFSR step: next = (state>>1) ^ (state[0] ? TAPS : 0). At most one step per edge when (en || FSM==DRAW). It never double-steps.
- seed_load has priority over stepping on the same edge. A loaded 0 becomes SEED, so the all-zero lockup is impossible. seed_load during busy is allowed: the draw continues from the new state.
- limit_eff = (latched limit==0) ? 2^OUT_W : latched limit (OUT_W+1 bits).
- FSM:
  - IDLE: on req=1, latch limit, clear tries, go to DRAW. busy=1 from the next cycle.
  - DRAW (each edge): cand = state[OUT_W-1:0] (pre-step state). LFSR steps.
    - If cand < limit_eff: value<=cand, valid<=1, go to IDLE.
    - Else, if tries==MAX_TRIES-1: rem<=cand, go to REDUCE.
    - Else tries++ and stay in DRAW.
  - REDUCE (each edge): if rem >= limit_eff, rem <= rem - limit_eff and stay. Otherwise value<=rem, valid<=1, go to IDLE. The LFSR steps only if en=1.
- Latency: req sampled at edge E0; the first DRAW evaluation is at E1. The best case is valid high for the cycle after E1. The worst case is MAX_TRIES DRAW cycles plus ceil(2^OUT_W/limit_eff) REDUCE cycles.
- valid is exactly one cycle wide. busy drops in the same cycle valid rises. req while busy is ignored (not queued). req high in the valid cycle is accepted on the next edge.
- limit changes while busy have no effect on the current draw.
- limit=1 always yields 0. limit=0 always accepts on the first DRAW.
- raw reflects the registered state every cycle.

Test Plan:
- Reset, then en=0 and no req for 10 cycles -> raw holds 0xACE1, valid=0, busy=0, value=0.
- en=1 from reset -> raw sequence 0xACE1, 0xE270, 0x7138, 0x389C, 0x1C4E, 0x0E27.
- req=1 with limit=40 from the reset state -> one DRAW, value=33 (0x21), valid one cycle after E1, raw=0xE270 afterwards.
- req with limit=20 from reset (MAX_TRIES=8) -> candidates 33, 48, 56, 28 rejected, 14 accepted. valid appears after 5 DRAW cycles and value=14. Second instance with MAX_TRIES=2 -> 33 and 48 rejected, REDUCE 48→28→8, value=8.
- seed_load=1 with seed_in=0 while en=1 -> raw=0xACE1 next cycle (seed beats step). seed_in=0x0001 -> raw=0x0001, then 0xB400.
- Assert rst during DRAW -> busy and valid go 0 immediately with no valid pulse; raw=0xACE1. req held during busy is ignored and a single valid results. limit=0 -> value = low 6 bits of the state in one DRAW.
